data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder side of the MCU data-memory interface. Accepts single-word load/store
//  requests from the MEM stage over a valid/ready handshake and holds them in a
//  word-organised storage array. Returns one response pulse per request after a
//  programmable number of wait states, so stall handling upstream can be exercised.
// PARAMETERS
//  ADDR_W       8   word-index width; storage depth = 2**ADDR_W words of 32 bits
//  WAIT_CYCLES  2   extra access cycles inserted before the response (0..15)
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept a request this cycle
//  req_write   in   1   1 = store, 0 = load
//  req_addr    in   32  byte address; word index = req_addr[ADDR_W+1:2]
//  req_wdata   in   32  store data
//  resp_valid  out  1   one-cycle response pulse
//  resp_rdata  out  32  load data; 0 for stores and errored requests
//  resp_err    out  1   request rejected; valid only with resp_valid
// BEHAVIOUR
//  - Reset: state IDLE, wait counter 0, resp_valid/resp_err 0, resp_rdata 0.
//    req_ready is 0 while reset is high. Storage array is not reset.
//  - FSM states are IDLE -> ACCESS -> RESP -> IDLE.
//  - IDLE: req_ready=1. On an edge with req_valid=1, latch write/addr/wdata,
//    load the counter with WAIT_CYCLES, and go to ACCESS.
//  - ACCESS: req_ready=0. The counter decrements each cycle.
//    The state lasts WAIT_CYCLES+1 cycles.
//    On the edge where the counter is 0:
//    - perform the write, or register the read data;
//    - enter RESP.
//  - RESP: req_ready=0, resp_valid=1 for exactly one cycle, then IDLE.
//    There is no response back-pressure; the initiator must sample it.
//  - Latency: acceptance edge k -> resp_valid high after edge k+WAIT_CYCLES+1.
//    Throughput: one request per WAIT_CYCLES+3 cycles.
//  - req_valid while busy: ignored and not queued. The initiator holds it until
//    req_ready=1. req_addr/req_wdata may change after acceptance without effect.
//  - resp_rdata/resp_err hold their last value outside RESP. They are only
//    meaningful with resp_valid.
//  - Reset asserted mid-ACCESS: the request is discarded. No write occurs if the
//    access edge was not reached, and no response is issued.
//  - Read and write of the same word never overlap; requests are serialised.
// CONFIGURATION
//  DMR_ERR_CHECK_EN defined:
//    - An error is raised when req_addr[1:0]!=0 (misaligned) or
//      req_addr[31:ADDR_W+2]!=0 (out of range).
//    - On error: no write, resp_rdata=0, resp_err=1, same latency.
//  DMR_ERR_CHECK_EN undefined:
//    - resp_err is tied to 0.
//    - req_addr[1:0] and the upper bits are ignored, so the address aliases
//      onto the word index.
// TESTING (ADDR_W=8, WAIT_CYCLES=2 unless stated)
//  1. Store 0xDEADBEEF to 0x10, then load 0x10 -> load resp_rdata=0xDEADBEEF,
//     resp_err=0. resp_valid is high exactly 3 edges after each acceptance,
//     for 1 cycle.
//  2. Hold req_valid=1 continuously with two loads -> req_ready=0 during
//     ACCESS/RESP. Second acceptance 5 cycles after the first; no request lost
//     or duplicated.
//  3. Store 0x11111111 to 0x13.
//     - With DMR_ERR_CHECK_EN: resp_err=1; a subsequent load of 0x10 is unchanged.
//     - Without it: the load of 0x10 returns 0x11111111.
//  4. Load 0x400 with DMR_ERR_CHECK_EN -> resp_err=1, resp_rdata=0.
//  5. Store 0xCAFEF00D to 0x20 (previously 0x12345678) and pulse reset in the
//     2nd ACCESS cycle -> no resp_valid; a later load of 0x20 returns 0x12345678.
//  6. WAIT_CYCLES=0: store then load 0x04 -> resp_valid 1 edge after each
//     acceptance; the data round-trips correctly.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
// Single-word requests over valid/ready, one-cycle response pulse with no back-pressure.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word storage with WAIT_CYCLES+1 access cycles, one response pulse per request.
// Latency accept->resp_valid = WAIT_CYCLES+1 edges; requests are refused (req_ready=0) while busy.
// Optional address checking (misaligned / out of range) is enabled by defining DMR_ERR_CHECK_EN.
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic                r_write;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_wdata;
    logic                r_err_pend;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic [31:0]         r_mem [DEPTH];

    logic                w_accept;
    logic                w_access_done;
    logic                w_addr_err;
    logic [ADDR_W-1:0]   w_idx;

    assign w_idx = bus.req_addr[ADDR_W+1:2];

`ifdef DMR_ERR_CHECK_EN
    assign w_addr_err = (bus.req_addr[1:0] != 2'b00) ||
                        ((bus.req_addr >> (ADDR_W + 2)) != 32'd0);
`else
    // Byte-offset and upper bits are dropped, so addresses alias onto the word index.
    logic w_unused_addr;
    assign w_unused_addr = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};
    assign w_addr_err    = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_access_done  = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = !reset;
                if (bus.req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_access_done = 1'b1;
                    w_state_nxt   = S_RESP;
                end
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                w_state_nxt    = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_write    <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            r_err_pend <= 1'b0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt      <= 4'(WAIT_CYCLES);
                r_write    <= bus.req_write;
                r_idx      <= w_idx;
                r_wdata    <= bus.req_wdata;
                r_err_pend <= w_addr_err;
            end else if (r_state == S_ACCESS && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Stores and rejected requests return zero data.
            if (w_access_done) begin
                r_err   <= r_err_pend;
                r_rdata <= (r_write || r_err_pend) ? 32'd0 : r_mem[r_idx];
            end
        end
    end

    // Storage is deliberately not reset; reset forces IDLE so no write can fire.
    always_ff @(posedge clk) begin
        if (w_access_done && r_write && !r_err_pend)
            r_mem[r_idx] <= r_wdata;
    end

    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: DUT0 with WAIT_CYCLES=2, DUT1 with WAIT_CYCLES=0.
// Expectations follow the build setting of DMR_ERR_CHECK_EN.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   checks   = 0;
    int   failures = 0;

`ifdef DMR_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    data_mem_responder_if if0 ();
    data_mem_responder_if if1 ();

    data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .reset(rst0), .bus(if0.slave)
    );
    data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(rst1), .bus(if1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic txn0(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        int n;
        int edges;
        @(negedge clk);
        if0.req_valid = 1'b1; if0.req_write = wr; if0.req_addr = addr; if0.req_wdata = wd;
        n = 0;
        while (!if0.req_ready && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_rdy"}, {31'd0, if0.req_ready}, 32'd1);
        @(posedge clk); #1;
        if0.req_valid = 1'b0; if0.req_addr = ~addr; if0.req_wdata = ~wd;
        edges = 0;
        while (!if0.resp_valid && edges < 20) begin @(posedge clk); edges++; @(negedge clk); end
        chk({tag, "_lat"}, edges, 32'd3);
        chk({tag, "_rdata"}, if0.resp_rdata, exp_rd);
        chk({tag, "_err"}, {31'd0, if0.resp_err}, {31'd0, exp_err});
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, if0.resp_valid}, 32'd0);
    endtask

    task automatic txn1(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd);
        int n;
        int edges;
        @(negedge clk);
        if1.req_valid = 1'b1; if1.req_write = wr; if1.req_addr = addr; if1.req_wdata = wd;
        n = 0;
        while (!if1.req_ready && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_rdy"}, {31'd0, if1.req_ready}, 32'd1);
        @(posedge clk); #1;
        if1.req_valid = 1'b0; if1.req_addr = ~addr; if1.req_wdata = ~wd;
        edges = 0;
        while (!if1.resp_valid && edges < 20) begin @(posedge clk); edges++; @(negedge clk); end
        chk({tag, "_lat"}, edges, 32'd1);
        chk({tag, "_rdata"}, if1.resp_rdata, exp_rd);
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, if1.resp_valid}, 32'd0);
    endtask

    initial begin
        int acc;
        int a1;
        int a2;
        int nresp;
        logic [31:0] rd1;
        logic [31:0] rd2;

        if0.req_valid = 1'b0; if0.req_write = 1'b0; if0.req_addr = 32'd0; if0.req_wdata = 32'd0;
        if1.req_valid = 1'b0; if1.req_write = 1'b0; if1.req_addr = 32'd0; if1.req_wdata = 32'd0;
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, if0.req_ready}, 32'd0);
        chk("rst_valid", {31'd0, if0.resp_valid}, 32'd0);
        chk("rst_rdata", if0.resp_rdata, 32'd0);
        chk("rst_err", {31'd0, if0.resp_err}, 32'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        #1;
        chk("idle_ready", {31'd0, if0.req_ready}, 32'd1);

        // Store/load round trip and a second word for later tests.
        txn0("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        txn0("ld10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        txn0("st20", 1'b1, 32'h20, 32'h12345678, 32'd0, 1'b0);

        // Back-to-back loads with req_valid held high the whole time.
        @(negedge clk);
        if0.req_valid = 1'b1; if0.req_write = 1'b0; if0.req_addr = 32'h10;
        acc = 0; a1 = -1; a2 = -1; nresp = 0; rd1 = 32'd0; rd2 = 32'd0;
        for (int i = 0; i < 20; i++) begin
            if (if0.resp_valid) begin
                nresp++;
                if (nresp == 1) rd1 = if0.resp_rdata; else rd2 = if0.resp_rdata;
            end
            if (if0.req_ready && if0.req_valid) begin
                acc++;
                if (acc == 1) a1 = i; else a2 = i;
            end
            @(posedge clk); #1;
            if (acc == 1) if0.req_addr = 32'h20;
            if (acc == 2) if0.req_valid = 1'b0;
            @(negedge clk);
        end
        chk("b2b_accepts", acc, 32'd2);
        chk("b2b_gap", a2 - a1, 32'd5);
        chk("b2b_resps", nresp, 32'd2);
        chk("b2b_rd1", rd1, 32'hDEADBEEF);
        chk("b2b_rd2", rd2, 32'h12345678);

        // Misaligned store: rejected with checking, aliases onto word 4 without.
        txn0("st13", 1'b1, 32'h13, 32'h11111111, 32'd0, ERR_EN);
        txn0("ld10b", 1'b0, 32'h10, 32'h0, ERR_EN ? 32'hDEADBEEF : 32'h11111111, 1'b0);
`ifdef DMR_ERR_CHECK_EN
        txn0("ld400", 1'b0, 32'h400, 32'h0, 32'd0, 1'b1);
`else
        txn0("ld410", 1'b0, 32'h410, 32'h0, 32'h11111111, 1'b0);
`endif

        // Reset pulse during the second ACCESS cycle discards the store.
        @(negedge clk);
        if0.req_valid = 1'b1; if0.req_write = 1'b1; if0.req_addr = 32'h20; if0.req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        if0.req_valid = 1'b0;
        @(posedge clk); #1;
        rst0 = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", {31'd0, if0.req_ready}, 32'd0);
        @(negedge clk);
        rst0 = 1'b0;
        nresp = 0;
        for (int i = 0; i < 6; i++) begin
            if (if0.resp_valid) nresp++;
            @(negedge clk);
        end
        chk("mid_rst_noresp", nresp, 32'd0);
        chk("mid_rst_rdata", if0.resp_rdata, 32'd0);
        txn0("ld20", 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0);

        // Zero wait states.
        txn1("w0_st04", 1'b1, 32'h04, 32'hA5A55A5A, 32'd0);
        txn1("w0_ld04", 1'b0, 32'h04, 32'h0, 32'hA5A55A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end
endmodule
